// File: rtl/counter_read_response_buffer.sv
// ---------------------------------------------------------------------------
// counter_read_response_buffer
//
// Captures READ responses from the SRAM multi-counter, which has no
// backpressure, into a circular FIFO and presents them to a consumer over a
// valid/ready handshake. It also counts READ commands still waiting for their
// response. From that count it drives a credit signal, so a well-behaved
// issuer never sends a READ whose response would find the FIFO full.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rd_issue      a READ command is presented to the counter this cycle
//   in_valid      counter response strobe
//   in_id         counter response id
//   in_data       counter response value
//   out_valid     head entry available
//   out_ready     consumer accepts the head entry
//   out_id        head entry id
//   out_data      head entry value
//   credit_ok     issuer may assert rd_issue this cycle
//   count         FIFO occupancy
//   overflow      sticky: a response was dropped because the FIFO was full
//   protocol_err  sticky: response with no READ outstanding, or READ without credit
// ---------------------------------------------------------------------------
module counter_read_response_buffer #(
    parameter int DEPTH  = 8,
    parameter int ID_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_issue,
    input  logic                   in_valid,
    input  logic [ID_W-1:0]        in_id,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [DATA_W-1:0]      out_data,
    output logic                   credit_ok,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ID_W-1:0]   id_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W:0]   credit_sum;

    logic pop;
    logic push;
    logic drop;
    logic perr_set;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // response when the consumer takes the head entry.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & ((count != FULL) | pop);
    assign drop = in_valid & (count == FULL) & ~pop;

    assign out_valid = (count != '0);
    assign out_id    = id_mem[rd_ptr];
    assign out_data  = data_mem[rd_ptr];

    // Credit depends only on registered state, so there is no combinational
    // path from rd_issue or in_valid back to the issuer.
    assign credit_sum = (CNT_W+1)'(count) + (CNT_W+1)'(outstanding);
    assign credit_ok  = credit_sum < (CNT_W+1)'(DEPTH);

    // NOTE: the entry storage has no reset; out_valid gates its contents, and
    // leaving it unreset lets it map onto plain register files or RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]   <= in_id;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Outstanding-READ bookkeeping. A READ and a response in the same cycle
    // cancel out. A stray response is flagged, and the count stays at zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        outstanding_next = outstanding;
        perr_set         = 1'b0;
        if (rd_issue && !credit_ok) begin
            perr_set = 1'b1;
        end
        if (rd_issue && !in_valid) begin
            if (outstanding != FULL) begin
                outstanding_next = outstanding + CNT_W'(1);
            end
        end else if (in_valid && !rd_issue) begin
            if (outstanding == '0) begin
                perr_set = 1'b1;
            end else begin
                outstanding_next = outstanding - CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            outstanding  <= '0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            outstanding <= outstanding_next;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (perr_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
